mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NCH, default 2: number of requester channels, legal range 2..8.
REQ-002 Parameter AW, default 8: byte-address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 req  in  NCH  per-channel access request, held high until the matching gnt bit is seen.
REQ-007 we  in  NCH  per-channel write enable (1 = store, 0 = load).
REQ-008 addr  in  NCH*AW  per-channel byte address, channel i at bits [i*AW +: AW].
REQ-009 wdata  in  NCH*DW  per-channel store data, channel i at bits [i*DW +: DW].
REQ-010 func3  in  NCH*3  per-channel size/sign code (RV32 load/store funct3).
REQ-011 gnt  out  NCH  one-hot grant; request accepted on the edge where gnt[i]=1.
REQ-012 rvalid  out  NCH  one-hot; load data for channel i is valid this cycle.
REQ-013 rdata  out  DW  load data shared by all channels, qualified by rvalid.
REQ-014 m_rd, m_wr  out  1 each  registered read and write strobes to the single-port memory.
REQ-015 m_addr  out  AW;  m_wdata  out  DW;  m_func3  out  3  registered memory command fields.
REQ-016 m_rdata  in  DW  memory read data, valid the cycle after m_rd=1.

Function
REQ-017 gnt is combinational from req and arbiter state; at most one bit is set; gnt=0 when req=0.
REQ-018 Winner is the first requesting channel at or after rr_ptr, searching upward modulo NCH.
REQ-019 On each accepted request, rr_ptr updates to winner+1 modulo NCH (wrap NCH-1 -> 0).
REQ-020 Command stage: the edge that accepts channel i loads m_* from channel i fields; m_rd=~we[i], m_wr=we[i]; with no acceptance, m_rd=m_wr=0 and other m_* hold their values.
REQ-021 Response stage: one cycle after m_rd=1, rvalid[owner]=1 and rdata=m_rdata; a store produces no rvalid.
REQ-022 Load latency is fixed: gnt in cycle N, m_rd in N+1, rvalid in N+2. Throughput is one access per cycle.
REQ-023 Back-to-back grants to different channels are allowed; response ordering equals grant ordering.
REQ-024 A channel that keeps req high after its grant makes a new request, arbitrated normally.
REQ-025 Starvation bound: a channel holding req high is granted within NCH cycles, lock excluded.

Reset
REQ-026 While rst=0: gnt=0, rvalid=0, m_rd=0, m_wr=0, m_addr=0, m_wdata=0, m_func3=0, rdata=0, rr_ptr=0, and lock state is UNLOCKED.
REQ-027 Reset asserted mid-access discards the in-flight command and response; no rvalid follows reset release.
REQ-028 First grant after reset release goes to the lowest-index requesting channel.

Configuration
REQ-029 Macro MEM_ARB_LOCK_EN, defined: adds input lock[NCH] and a 2-state FSM, UNLOCKED and LOCKED(owner).
REQ-030 With MEM_ARB_LOCK_EN, an accepted request with lock[i]=1 moves the FSM to LOCKED(i).
REQ-031 With MEM_ARB_LOCK_EN, in LOCKED(i) only channel i can be granted; an accepted request with lock[i]=0, or req[i]=0 for a cycle, returns the FSM to UNLOCKED.
REQ-032 With MEM_ARB_LOCK_EN, rr_ptr does not advance while LOCKED.
REQ-033 Without MEM_ARB_LOCK_EN: the lock port and FSM are absent; behaviour is pure round-robin.

Structure
REQ-034 Shared package core_pkg holds the funct3 size codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the lock-FSM state encoding.
REQ-035 A single sub-module rr_picker (NCH-wide rotate, priority-encode, one-hot out) computes the winner.

Verification
REQ-036 NCH=2, rst=0 then released; req=2'b11, we=0 -> gnt=01 in cycle 1; gnt=10 in cycle 2; rvalid=01 then 10 at cycles 3 and 4.
REQ-037 Channel 1 store addr=8'h10, wdata=32'hDEADBEEF, func3=SW, then channel 0 load from 8'h10 -> m_wr then m_rd on consecutive cycles; rvalid[0] with rdata=32'hDEADBEEF.
REQ-038 NCH=4, req=4'b1111 held for 8 cycles -> gnt sequence 1,2,4,8,1,2,4,8, including wrap 3->0.
REQ-039 Reset asserted the cycle after a load grant -> m_rd=0 and rvalid=0 immediately; no rvalid after release.
REQ-040 MEM_ARB_LOCK_EN, ch0 load with lock=1 then req=2'b11 for 3 cycles -> ch0 granted 3 times and ch1 stalled; ch0 lock=0 -> ch1 granted the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the memory arbiter: RV32 load/store size codes and
// the lock-FSM state encoding used when MEM_ARB_LOCK_EN is defined.
package core_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: rotate requests so rr_ptr lands at bit 0,
// pick the lowest set bit, then rotate the index back into channel space.
module rr_picker #(
  parameter int NCH = 2,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  winner,
  output logic           valid
);

  logic [NCH-1:0] rotated;
  logic [PW-1:0]  offset;

  always_comb begin
    rotated = NCH'({req, req} >> ptr);
    offset  = '0;
    valid   = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = PW'(i);
        valid  = 1'b1;
      end
    end
    winner = PW'((int'(offset) + int'(ptr)) % NCH);
    gnt    = '0;
    if (valid) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter in front of a single-port memory, with a
// registered command stage and a one-cycle load response stage.
// Optional bus locking is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 8,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  input  logic [NCH*3-1:0]  func3,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NCH-1:0]    lock,
`endif
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    rvalid,
  output logic [DW-1:0]     rdata,
  output logic              m_rd,
  output logic              m_wr,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  output logic [2:0]        m_func3,
  input  logic [DW-1:0]     m_rdata
);

  localparam int PW = $clog2(NCH);

  logic [NCH-1:0] arb_req;
  logic [NCH-1:0] pick_gnt;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  winner;
  logic [PW-1:0]  ptr_inc;
  logic [PW-1:0]  cmd_owner;
  logic           pick_valid;
  logic           accept;
  logic           advance;

`ifdef MEM_ARB_LOCK_EN
  lock_state_e   state, state_nxt;
  logic [PW-1:0] lock_owner, lock_owner_nxt;

  // While locked only the owner may compete, and the pointer is frozen.
  assign arb_req = (state == LOCKED) ? (req & (NCH'(1) << lock_owner)) : req;
  assign advance = accept && (state == UNLOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= UNLOCKED;
      lock_owner <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= lock_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    lock_owner_nxt = lock_owner;
    case (state)
      UNLOCKED: begin
        if (accept && lock[winner]) begin
          state_nxt      = LOCKED;
          lock_owner_nxt = winner;
        end
      end
      LOCKED: begin
        if (!req[lock_owner] || (accept && !lock[lock_owner])) state_nxt = UNLOCKED;
      end
    endcase
  end
`else
  assign arb_req = req;
  assign advance = accept;
`endif

  rr_picker #(.NCH(NCH), .PW(PW)) u_picker (
    .req    (arb_req),
    .ptr    (rr_ptr),
    .gnt    (pick_gnt),
    .winner (winner),
    .valid  (pick_valid)
  );

  assign accept  = pick_valid && rst;
  assign gnt     = accept ? pick_gnt : '0;
  assign ptr_inc = (winner == PW'(NCH - 1)) ? '0 : winner + PW'(1);
  assign rdata   = (|rvalid) ? m_rdata : '0;

  // Command stage captures the winner's fields; response stage tags the
  // returning load data with the channel that issued it one cycle earlier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_func3   <= '0;
      cmd_owner <= '0;
      rvalid    <= '0;
    end else begin
      if (advance) rr_ptr <= ptr_inc;
      m_rd <= accept && !we[winner];
      m_wr <= accept && we[winner];
      if (accept) begin
        m_addr    <= addr[int'(winner)*AW +: AW];
        m_wdata   <= wdata[int'(winner)*DW +: DW];
        m_func3   <= func3[int'(winner)*3 +: 3];
        cmd_owner <= winner;
      end
      rvalid <= m_rd ? (NCH'(1) << cmd_owner) : '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps on a 2-channel and a
// 4-channel instance, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req2, we2, gnt2, rvalid2;
  logic [15:0] addr2;
  logic [63:0] wdata2;
  logic [5:0]  func3_2;
  logic [31:0] rdata2, m_wdata2, m_rdata2;
  logic        m_rd2, m_wr2;
  logic [7:0]  m_addr2;
  logic [2:0]  m_func3_2;

  logic [3:0]   req4, we4, gnt4, rvalid4;
  logic [31:0]  addr4;
  logic [127:0] wdata4;
  logic [11:0]  func3_4;
  logic [31:0]  rdata4, m_wdata4, m_rdata4;
  logic         m_rd4, m_wr4;
  logic [7:0]   m_addr4;
  logic [2:0]   m_func3_4;

`ifdef MEM_ARB_LOCK_EN
  logic [1:0] lock2;
  logic [3:0] lock4;
`endif

  mem_arbiter #(.NCH(2), .AW(8), .DW(32)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2), .func3(func3_2),
`ifdef MEM_ARB_LOCK_EN
    .lock(lock2),
`endif
    .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .m_rd(m_rd2), .m_wr(m_wr2),
    .m_addr(m_addr2), .m_wdata(m_wdata2), .m_func3(m_func3_2), .m_rdata(m_rdata2)
  );

  mem_arbiter #(.NCH(4), .AW(8), .DW(32)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4), .func3(func3_4),
`ifdef MEM_ARB_LOCK_EN
    .lock(lock4),
`endif
    .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4), .m_rd(m_rd4), .m_wr(m_wr4),
    .m_addr(m_addr4), .m_wdata(m_wdata4), .m_func3(m_func3_4), .m_rdata(m_rdata4)
  );

  function automatic logic [31:0] pat(int a);
    return 32'hA5C3_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  // Single-port memories: data returns the cycle after the read strobe.
  logic [31:0] mem2 [256];
  logic [31:0] mem4 [256];
  logic [31:0] ref_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem2[i] = pat(i);
    forever begin
      @(posedge clk);
      if (m_wr2) mem2[m_addr2] = m_wdata2;
      if (m_rd2) m_rdata2 <= mem2[m_addr2];
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem4[i] = pat(i);
    forever begin
      @(posedge clk);
      if (m_wr4) mem4[m_addr4] = m_wdata4;
      if (m_rd4) m_rdata4 <= mem4[m_addr4];
    end
  end

  int checks;
  int failures;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input logic [2:0] f);
    we2[ch]             = w;
    addr2[ch*8 +: 8]    = a;
    wdata2[ch*32 +: 32] = d;
    func3_2[ch*3 +: 3]  = f;
  endtask

  // Transaction-level model state for the randomized run on the 4-channel instance.
  int          mptr, win, cur_owner, prev_owner;
  bit          pend [4];
  int          wait_cnt [4];
  logic        p_we [4];
  logic [7:0]  p_addr [4];
  logic [31:0] p_wdata [4];
  logic [2:0]  p_f3 [4];
  bit          cur_load, cur_store, prev_load;
  logic [31:0] cur_data, prev_data, exp_wdata;
  logic [7:0]  exp_addr;
  logic [2:0]  exp_f3;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0; func3_2 = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0; func3_4 = '0;
`ifdef MEM_ARB_LOCK_EN
    lock2 = '0;
    lock4 = '0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

    repeat (2) @(negedge clk);
    req2 = 2'b11;
    req4 = 4'hF;
    #1;
    checkOutput("rst_gnt2", gnt2, 0);
    checkOutput("rst_gnt4", gnt4, 0);
    checkOutput("rst_rvalid2", rvalid2, 0);
    checkOutput("rst_m_rd2", m_rd2, 0);
    checkOutput("rst_m_wr2", m_wr2, 0);
    checkOutput("rst_m_addr2", m_addr2, 0);
    checkOutput("rst_m_wdata2", m_wdata2, 0);
    checkOutput("rst_m_func3_2", m_func3_2, 0);
    checkOutput("rst_rdata2", rdata2, 0);
    checkOutput("rst_rvalid4", rvalid4, 0);
    checkOutput("rst_m_rd4", m_rd4, 0);
    req2 = '0;
    req4 = '0;

    // Two loads back to back on the 2-channel instance.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 1'b0, 8'h04, 32'h0, LW);
    applyStimulus(1, 1'b0, 8'h08, 32'h0, LW);
    req2 = 2'b11;
    #1 checkOutput("rr2_gnt_c1", gnt2, 2'b01);
    @(posedge clk); #1;
    checkOutput("rr2_m_rd_c2", m_rd2, 1);
    checkOutput("rr2_m_addr_c2", m_addr2, 8'h04);
    @(negedge clk); #1;
    checkOutput("rr2_gnt_c2", gnt2, 2'b10);
    @(posedge clk); #1;
    checkOutput("rr2_rvalid_c3", rvalid2, 2'b01);
    checkOutput("rr2_rdata_c3", rdata2, pat(8'h04));
    checkOutput("rr2_m_addr_c3", m_addr2, 8'h08);

    // Store from channel 1 followed by a load of the same word from channel 0.
    @(negedge clk);
    applyStimulus(1, 1'b1, 8'h10, 32'hDEADBEEF, SW);
    req2 = 2'b10;
    #1 checkOutput("st_gnt", gnt2, 2'b10);
    @(posedge clk); #1;
    checkOutput("rr2_rvalid_c4", rvalid2, 2'b10);
    checkOutput("rr2_rdata_c4", rdata2, pat(8'h08));
    checkOutput("st_m_wr", m_wr2, 1);
    checkOutput("st_m_rd", m_rd2, 0);
    checkOutput("st_m_addr", m_addr2, 8'h10);
    checkOutput("st_m_wdata", m_wdata2, 32'hDEADBEEF);
    checkOutput("st_m_func3", m_func3_2, SW);
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h10, 32'h0, LW);
    req2 = 2'b01;
    #1 checkOutput("ld_gnt", gnt2, 2'b01);
    @(posedge clk); #1;
    checkOutput("ld_m_rd", m_rd2, 1);
    checkOutput("ld_m_wr", m_wr2, 0);
    checkOutput("ld_no_rvalid_for_store", rvalid2, 0);
    @(negedge clk);
    req2 = 2'b00;
    @(posedge clk); #1;
    checkOutput("ld_rvalid", rvalid2, 2'b01);
    checkOutput("ld_rdata", rdata2, 32'hDEADBEEF);

    // Reset in the cycle after a load grant kills the access.
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h20, 32'h0, LW);
    req2 = 2'b01;
    #1 checkOutput("rst_mid_gnt", gnt2, 2'b01);
    @(posedge clk); #1;
    checkOutput("rst_mid_m_rd_before", m_rd2, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_mid_m_rd", m_rd2, 0);
    checkOutput("rst_mid_rvalid", rvalid2, 0);
    checkOutput("rst_mid_gnt_off", gnt2, 0);
    @(negedge clk);
    req2 = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("post_rst_rvalid", rvalid2, 0);
      checkOutput("post_rst_m_rd", m_rd2, 0);
    end
    @(negedge clk);
    applyStimulus(1, 1'b0, 8'h08, 32'h0, LW);
    req2 = 2'b11;
    #1 checkOutput("first_after_rst", gnt2, 2'b01);
    @(negedge clk);
    req2 = 2'b00;
    repeat (3) @(posedge clk);

    // Four-channel rotation with all requests held, including the 3 -> 0 wrap.
    for (int c = 0; c < 4; c++) addr4[c*8 +: 8] = 8'(8'h40 + c * 4);
    func3_4 = {LW, LW, LW, LW};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req4 = 4'hF;
      #1 checkOutput("rr4_gnt", gnt4, 32'd1 << (k % 4));
    end
    @(negedge clk);
    req4 = '0;
    repeat (3) @(posedge clk);

    // Randomized traffic on the 4-channel instance.
    mptr = 0;
    prev_load = 1'b0;
    prev_owner = 0;
    prev_data = '0;
    cur_owner = 0;
    cur_data = '0;
    exp_addr = 8'h4C;
    exp_wdata = '0;
    exp_f3 = LW;
    for (int c = 0; c < 4; c++) begin
      pend[c] = 1'b0; wait_cnt[c] = 0; p_we[c] = 1'b0;
      p_addr[c] = '0; p_wdata[c] = '0; p_f3[c] = '0;
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (!pend[c] && $urandom_range(0, 99) < 45) begin
          pend[c]     = 1'b1;
          wait_cnt[c] = 0;
          p_we[c]     = 1'($urandom_range(0, 1));
          p_addr[c]   = 8'($urandom_range(0, 15));
          p_wdata[c]  = $urandom;
          p_f3[c]     = 3'($urandom_range(0, 7));
        end
        req4[c]              = pend[c];
        we4[c]               = p_we[c];
        addr4[c*8 +: 8]      = p_addr[c];
        wdata4[c*32 +: 32]   = p_wdata[c];
        func3_4[c*3 +: 3]    = p_f3[c];
      end
      #1;
      win = -1;
      for (int k = 0; k < 4; k++)
        if (win < 0 && pend[(mptr + k) % 4]) win = (mptr + k) % 4;
      checkOutput("rand_gnt", gnt4, (win < 0) ? 32'd0 : (32'd1 << win));
      for (int c = 0; c < 4; c++)
        if (pend[c] && c != win) wait_cnt[c]++;
      cur_load = 1'b0;
      cur_store = 1'b0;
      if (win >= 0) begin
        checkOutput("rand_starve", wait_cnt[win] < 4, 1);
        mptr = (win + 1) % 4;
        pend[win] = 1'b0;
        cur_owner = win;
        exp_addr  = p_addr[win];
        exp_wdata = p_wdata[win];
        exp_f3    = p_f3[win];
        if (p_we[win]) begin
          ref_mem[p_addr[win]] = p_wdata[win];
          cur_store = 1'b1;
        end else begin
          cur_data = ref_mem[p_addr[win]];
          cur_load = 1'b1;
        end
      end
      @(posedge clk); #1;
      checkOutput("rand_m_rd", m_rd4, cur_load);
      checkOutput("rand_m_wr", m_wr4, cur_store);
      checkOutput("rand_m_addr", m_addr4, exp_addr);
      checkOutput("rand_m_wdata", m_wdata4, exp_wdata);
      checkOutput("rand_m_func3", m_func3_4, exp_f3);
      checkOutput("rand_rvalid", rvalid4, prev_load ? (32'd1 << prev_owner) : 32'd0);
      if (prev_load) checkOutput("rand_rdata", rdata4, prev_data);
      prev_load  = cur_load;
      prev_owner = cur_owner;
      prev_data  = cur_data;
    end
    @(negedge clk);
    req4 = '0;
    repeat (3) @(posedge clk);

`ifdef MEM_ARB_LOCK_EN
    // Channel 0 locks the bus; channel 1 waits until the unlocking access.
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h30, 32'h0, LW);
    applyStimulus(1, 1'b0, 8'h34, 32'h0, LW);
    lock2 = 2'b01;
    req2 = 2'b01;
    #1 checkOutput("lock_first_gnt", gnt2, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req2 = 2'b11;
      #1 checkOutput("lock_hold_gnt", gnt2, 2'b01);
    end
    @(negedge clk);
    lock2 = 2'b00;
    #1 checkOutput("lock_release_gnt", gnt2, 2'b01);
    @(negedge clk);
    #1 checkOutput("lock_after_gnt", gnt2, 2'b10);
    @(negedge clk);
    req2 = 2'b00;
    repeat (3) @(posedge clk);
`endif

    $display("[TB] directed and randomized sequences complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
